master_spi: RTL

MASTER_SPI -- requirements
Module: master_spi

---
 rtl/master_spi_pkg.sv | 26 ++
 rtl/master_spi_clk_div.sv | 44 ++++
 rtl/master_spi.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/master_spi_pkg.sv
// master_spi_pkg
//   Shared definitions for the mode-0 SPI master:
//   - default frame length and clock-divider width
//   - FSM state encoding (exported on the debug port of master_spi)
//   - helper for sizing the SCLK edge counter
package master_spi_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CDIV_W_DEF = 8;

  // Frame phases. IDLE is the reset state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  // The edge counter must hold the value 2*data_w without wrapping,
  // hence one bit more than clog2(2*data_w).
  function automatic int edge_cnt_w(input int data_w);
    return $clog2(2 * data_w) + 1;
  endfunction

endpackage

// File: rtl/master_spi_clk_div.sv
// spi_clk_div
//   Half-period timer for the SPI master. While run=1 it emits a one-cycle
//   tick every (div+1) clk cycles. restart (or run=0) puts the counter back
//   to zero so the first tick of a frame lands exactly div+1 cycles after
//   the frame is accepted.
//
// Ports
//   clk      in   system clock
//   rstn     in   asynchronous active-low reset
//   restart  in   restart the half-period count (frame accept cycle)
//   run      in   counting enable (high while a frame is in progress)
//   div      in   CDIV_W  half-period select, H = div+1
//   tick     out  one-cycle pulse at the end of each half-period
module spi_clk_div
  import master_spi_pkg::*;
#(
  parameter int CDIV_W = CDIV_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              restart,
  input  logic              run,
  input  logic [CDIV_W-1:0] div,
  output logic              tick
);

  logic [CDIV_W-1:0] cnt;

  // The counter never passes div, so it cannot wrap mid-frame.
  assign tick = run && !restart && (cnt == div);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (restart || !run) begin
      cnt <= '0;
    end else if (cnt == div) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CDIV_W'(1);
    end
  end

endmodule

// File: rtl/master_spi.sv
// master_spi
//   SPI master, mode 0 (SCLK idle low, data sampled on the rising edge,
//   changed on the falling edge), MSB first, fixed DATA_W-bit frames.
//
//   Frame timeline, H = ClockDiv+1 clk cycles:
//     SETUP  H cycles        SS_n=0, SCLK=0, MOSI = first bit
//     XFER   2*DATA_W*H      SCLK toggles at each half-period end
//     HOLD   H cycles        SS_n=0, SCLK=0
//     GAP    H cycles        SS_n=1
//   Busy is therefore high for H*(2*DATA_W+3) cycles.
//
//   Request/response: Start is a level sampled every clk. It is accepted
//   only in IDLE when Done is not being presented; acceptance captures
//   DataIn and ClockDiv and raises Busy on the same edge. Start is ignored
//   for the whole time Busy=1 and in the Done cycle. Done is a one-cycle
//   pulse coinciding with DataOut being updated and Busy falling.
//
// Ports
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   ClockDiv   in   CDIV_W  SCLK half-period select
//   Start      in   transfer request
//   DataIn     in   DATA_W  word to transmit
//   Busy       out  frame in progress
//   Done       out  end-of-frame pulse
//   DataOut    out  DATA_W  last received word (held between frames)
//   SCLK       out  SPI clock
//   MOSI       out  serial data out
//   MISO       in   serial data in
//   SS_n       out  slave select, active low
//   state_dbg  out  current FSM state
module master_spi
  import master_spi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CDIV_W = CDIV_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [CDIV_W-1:0] ClockDiv,
  input  logic              Start,
  input  logic [DATA_W-1:0] DataIn,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] DataOut,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SS_n,
  output spi_state_e        state_dbg
);

  localparam int            EW        = edge_cnt_w(DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

  spi_state_e        state, state_n;
  logic              sclk_q, sclk_n;
  logic              ss_n_q, ss_n_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic [DATA_W-1:0] tx_sh, tx_n;
  logic [DATA_W-1:0] rx_sh, rx_n;
  logic [DATA_W-1:0] dout_q, dout_n;
  logic [CDIV_W-1:0] div_q, div_n;
  logic [EW-1:0]     edge_cnt, edge_n;
  logic              restart;
  logic              tick;

  spi_clk_div #(
    .CDIV_W (CDIV_W)
  ) u_clk_div (
    .clk     (clk),
    .rstn    (rstn),
    .restart (restart),
    .run     (busy_q),
    .div     (div_q),
    .tick    (tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      sclk_q   <= 1'b0;
      ss_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      dout_q   <= '0;
      div_q    <= '0;
      edge_cnt <= '0;
    end else begin
      state    <= state_n;
      sclk_q   <= sclk_n;
      ss_n_q   <= ss_n_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      tx_sh    <= tx_n;
      rx_sh    <= rx_n;
      dout_q   <= dout_n;
      div_q    <= div_n;
      edge_cnt <= edge_n;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_n = state;
    sclk_n  = sclk_q;
    ss_n_n  = ss_n_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    tx_n    = tx_sh;
    rx_n    = rx_sh;
    dout_n  = dout_q;
    div_n   = div_q;
    edge_n  = edge_cnt;
    restart = 1'b0;

    case (state)
      ST_IDLE: begin
        // done_q still high means this is the Done cycle: no new frame.
        if (Start && !done_q) begin
          state_n = ST_SETUP;
          tx_n    = DataIn;
          div_n   = ClockDiv;
          ss_n_n  = 1'b0;
          busy_n  = 1'b1;
          sclk_n  = 1'b0;
          rx_n    = '0;
          edge_n  = '0;
          restart = 1'b1;
        end
      end

      ST_SETUP: begin
        if (tick) begin
          state_n = ST_XFER;
        end
      end

      ST_XFER: begin
        if (tick) begin
          sclk_n = ~sclk_q;
          edge_n = edge_cnt + EW'(1);
          if (!sclk_q) begin
            // Rising edge: sample the slave's bit.
            rx_n = {rx_sh[DATA_W-2:0], MISO};
          end else if (edge_n != LAST_EDGE) begin
            // Falling edge: present the next bit. After the last falling
            // edge MOSI keeps the final bit rather than shifting in a zero.
            tx_n = {tx_sh[DATA_W-2:0], 1'b0};
          end
          if (edge_n == LAST_EDGE) begin
            state_n = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (tick) begin
          state_n = ST_GAP;
          ss_n_n  = 1'b1;
        end
      end

      ST_GAP: begin
        if (tick) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          dout_n  = rx_sh;
        end
      end

      default: begin
        state_n = ST_IDLE;
        ss_n_n  = 1'b1;
        sclk_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DataOut   = dout_q;
  assign SCLK      = sclk_q;
  assign MOSI      = tx_sh[DATA_W-1];
  assign SS_n      = ss_n_q;
  assign state_dbg = state;

endmodule
